// File: rtl/dnn_infer_ctrl.sv
// dnn_infer_ctrl: sequencer for the fixed-point sigmoid inference engine.
// It accepts a host request, pulses engine clear then start, and waits for
// done under a watchdog. It then scans the class outputs for the argmax and
// returns class/score over a valid/ready handshake. It also arbitrates the
// shared memory address port between the host loader and the engine.
// Optional build macro: DNN_CTRL_PERF_EN enables the perf_cycles counter;
// without it perf_cycles is tied to zero.
module dnn_infer_ctrl #(
  parameter int DATA_WIDTH     = 11,
  parameter int ADDR_WIDTH     = 16,
  parameter int NUM_CLASSES    = 10,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              host_mem_req,
  input  logic [ADDR_WIDTH-1:0]             host_mem_addr,
  output logic                              host_mem_gnt,
  output logic                              eng_start,
  output logic                              eng_reset,
  input  logic                              eng_done,
  input  logic [ADDR_WIDTH-1:0]             eng_mem_addr,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] eng_out,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [3:0]                        res_class,
  output logic [DATA_WIDTH-1:0]             res_score,
  output logic                              res_timeout,
  output logic                              busy,
  output logic [31:0]                       perf_cycles
);

  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_SCAN  = 3'd4,
    S_HOLD  = 3'd5
  } state_t;

  state_t                        r_state;
  logic                          r_eng_start;
  logic                          r_eng_reset;
  logic                          r_res_valid;
  logic                          r_res_timeout;
  logic [3:0]                    r_res_class;
  logic signed [DATA_WIDTH-1:0]  r_res_score;
  logic [CNT_W-1:0]              r_run_cnt;
  logic [IDX_W-1:0]              r_scan_idx;
  logic [IDX_W-1:0]              r_best_idx;
  logic signed [DATA_WIDTH-1:0]  r_best_val;

  logic                          w_host_owned;
  logic                          w_accept;
  logic                          w_snap_en;
  logic signed [DATA_WIDTH-1:0]  w_snap [NUM_CLASSES];
  logic signed [DATA_WIDTH-1:0]  w_entry;
  logic                          w_take;
  logic signed [DATA_WIDTH-1:0]  w_new_val;
  logic [IDX_W-1:0]              w_new_idx;

  // Host owns the memory port whenever the engine cannot be touching it.
  assign w_host_owned = (r_state == S_IDLE) || (r_state == S_HOLD);
  assign mem_addr     = w_host_owned ? host_mem_addr : eng_mem_addr;
  assign host_mem_gnt = host_mem_req && w_host_owned;

  // A pending host memory access blocks a new inference from starting.
  assign req_ready = (r_state == S_IDLE) && !host_mem_req;
  assign w_accept  = req_valid && req_ready;
  assign busy      = (r_state != S_IDLE);

  // Engine outputs are only captured on a done seen while running.
  assign w_snap_en = (r_state == S_RUN) && eng_done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_snap
      logic signed [DATA_WIDTH-1:0] r_entry;

      // Capture this class output at completion so the scan sees a stable image.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_entry <= '0;
        end else if (w_snap_en) begin
          r_entry <= eng_out[gi*DATA_WIDTH +: DATA_WIDTH];
        end
      end

      assign w_snap[gi] = r_entry;
    end
  endgenerate

  // Strictly-greater replacement keeps the lowest index on ties; entry 0 seeds.
  assign w_entry   = w_snap[r_scan_idx];
  assign w_take    = (r_scan_idx == '0) || (w_entry > r_best_val);
  assign w_new_val = w_take ? w_entry : r_best_val;
  assign w_new_idx = w_take ? r_scan_idx : r_best_idx;

  // Main sequencer: request, clear, start, run with watchdog, scan, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_eng_start   <= 1'b0;
      r_eng_reset   <= 1'b0;
      r_res_valid   <= 1'b0;
      r_res_timeout <= 1'b0;
      r_res_class   <= '0;
      r_res_score   <= '0;
      r_run_cnt     <= '0;
      r_scan_idx    <= '0;
      r_best_idx    <= '0;
      r_best_val    <= '0;
    end else begin
      r_eng_start <= 1'b0;
      r_eng_reset <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_CLEAR;
            r_eng_reset <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_state     <= S_START;
          r_eng_start <= 1'b1;
        end
        S_START: begin
          r_state   <= S_RUN;
          r_run_cnt <= '0;
        end
        S_RUN: begin
          if (eng_done) begin
            r_state    <= S_SCAN;
            r_scan_idx <= '0;
          end else if (r_run_cnt == LAST_CNT) begin
            r_state       <= S_HOLD;
            r_eng_reset   <= 1'b1;
            r_res_valid   <= 1'b1;
            r_res_timeout <= 1'b1;
            r_res_class   <= '0;
            r_res_score   <= '0;
          end else begin
            r_run_cnt <= r_run_cnt + 1'b1;
          end
        end
        S_SCAN: begin
          r_best_val <= w_new_val;
          r_best_idx <= w_new_idx;
          r_scan_idx <= r_scan_idx + 1'b1;
          if (r_scan_idx == LAST_IDX) begin
            r_state       <= S_HOLD;
            r_res_valid   <= 1'b1;
            r_res_timeout <= 1'b0;
            r_res_class   <= 4'(w_new_idx);
            r_res_score   <= w_new_val;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign eng_start   = r_eng_start;
  assign eng_reset   = r_eng_reset;
  assign res_valid   = r_res_valid;
  assign res_timeout = r_res_timeout;
  assign res_class   = r_res_class;
  assign res_score   = r_res_score;

`ifdef DNN_CTRL_PERF_EN
  logic [31:0] r_perf;

  // Count RUN cycles of the current inference; frozen outside RUN, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf <= '0;
    end else if (r_state == S_START) begin
      r_perf <= '0;
    end else if ((r_state == S_RUN) && (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_dnn_infer_ctrl.sv
// Scoreboard bench for dnn_infer_ctrl: stimulus pushes the hand-computed
// result, a negedge monitor pops and compares on each result handshake.
module tb_dnn_infer_ctrl;
  localparam int DW = 11;
  localparam int AW = 16;
  localparam int NC = 10;
  localparam int TO = 64;

  typedef int vec_t [NC];
  typedef struct packed {
    logic          to;
    logic [3:0]    cls;
    logic [DW-1:0] score;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             host_mem_req;
  logic [AW-1:0]    host_mem_addr;
  logic             host_mem_gnt;
  logic             eng_start;
  logic             eng_reset;
  logic             eng_done;
  logic [AW-1:0]    eng_mem_addr;
  logic [NC*DW-1:0] eng_out;
  logic [AW-1:0]    mem_addr;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_class;
  logic [DW-1:0]    res_score;
  logic             res_timeout;
  logic             busy;
  logic [31:0]      perf_cycles;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  dnn_infer_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CLASSES(NC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .host_mem_req(host_mem_req), .host_mem_addr(host_mem_addr), .host_mem_gnt(host_mem_gnt),
    .eng_start(eng_start), .eng_reset(eng_reset), .eng_done(eng_done),
    .eng_mem_addr(eng_mem_addr), .eng_out(eng_out), .mem_addr(mem_addr),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_score(res_score), .res_timeout(res_timeout), .busy(busy),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*DW-1:0] pack(input vec_t v);
    logic [NC*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i*DW +: DW] = DW'(v[i]);
    return r;
  endfunction

  // Monitor: one comparison set per result handshake.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got class %0d score %0h with no expected entry", res_class, res_score);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_class", 32'(res_class), 32'(e.cls));
        chk("sb_score", 32'(res_score), 32'(e.score));
        chk("sb_timeout", 32'(res_timeout), 32'(e.to));
        $display("result: class=%0d score=%0d timeout=%0d", res_class, $signed(res_score), res_timeout);
      end
    end
  end

  // One full inference; delay==0 means the engine never finishes.
  task automatic run_inf(input logic [NC*DW-1:0] outs, input int delay, input logic [3:0] ecls,
                         input logic [DW-1:0] escore, input bit eto, input int hold, input bit hostreq);
    exp_t e;
    int   exp_perf;
    e.to = eto; e.cls = ecls; e.score = escore;
    sb_q.push_back(e);
    req_valid = 1'b1;
    #1;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    tick();
    req_valid    = 1'b0;
    host_mem_req = hostreq;
    #1;
    // CLEAR cycle
    chk("eng_reset_clear", 32'(eng_reset), 32'd1);
    chk("eng_start_clear", 32'(eng_start), 32'd0);
    chk("busy_clear", 32'(busy), 32'd1);
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (hostreq) begin
      chk("gnt_clear", 32'(host_mem_gnt), 32'd0);
      chk("addr_clear", 32'(mem_addr), 32'(eng_mem_addr));
    end
    tick();
    #1;
    // START cycle
    chk("eng_start_pulse", 32'(eng_start), 32'd1);
    chk("eng_reset_start", 32'(eng_reset), 32'd0);
    tick();
    if (delay > 0) begin
      for (int c = 1; c < delay; c++) begin
        #1;
        chk("eng_start_run", 32'(eng_start), 32'd0);
        if (hostreq) chk("gnt_run", 32'(host_mem_gnt), 32'd0);
        tick();
      end
      eng_done = 1'b1;
      eng_out  = outs;
      tick();
      eng_done = 1'b0;
      eng_out  = ~outs;
      for (int k = 1; k <= NC; k++) begin
        #1;
        chk("res_valid_scan", 32'(res_valid), 32'd0);
        if (hostreq) chk("addr_scan", 32'(mem_addr), 32'(eng_mem_addr));
        tick();
      end
      exp_perf = delay;
    end else begin
      for (int c = 1; c <= TO; c++) begin
        #1;
        chk("res_valid_run", 32'(res_valid), 32'd0);
        tick();
      end
      exp_perf = TO;
    end
`ifndef DNN_CTRL_PERF_EN
    exp_perf = 0;
`endif
    #1;
    chk("res_valid_hold", 32'(res_valid), 32'd1);
    chk("perf_cycles", perf_cycles, 32'(exp_perf));
    if (hostreq) begin
      chk("gnt_hold", 32'(host_mem_gnt), 32'd1);
      chk("addr_hold", 32'(mem_addr), 32'(host_mem_addr));
    end
    for (int h = 0; h < hold; h++) begin
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_class", 32'(res_class), 32'(ecls));
      chk("hold_score", 32'(res_score), 32'(escore));
      chk("hold_timeout", 32'(res_timeout), 32'(eto));
      chk("hold_perf", perf_cycles, 32'(exp_perf));
      if (h == 0) chk("eng_reset_abort", 32'(eng_reset), 32'(eto));
      else        chk("eng_reset_hold", 32'(eng_reset), 32'd0);
      if (eto && h == 0) eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      #1;
    end
    res_ready = 1'b1;
    tick();
    res_ready    = 1'b0;
    host_mem_req = 1'b0;
    #1;
    chk("res_valid_drop", 32'(res_valid), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    rst = 1'b1; req_valid = 1'b0; host_mem_req = 1'b0; host_mem_addr = 16'hAAAA;
    eng_done = 1'b0; eng_mem_addr = 16'h5555; eng_out = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_eng_reset", 32'(eng_reset), 32'd0);
    chk("rst_res_class", 32'(res_class), 32'd0);
    chk("rst_res_score", 32'(res_score), 32'd0);
    chk("rst_res_timeout", 32'(res_timeout), 32'd0);
    chk("rst_perf", perf_cycles, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Basic: argmax at class 2 (120 beats 119)
    v = '{-3, 7, 120, -1024, 5, 0, 119, 2, 3, 4};
    run_inf(pack(v), 50, 4'd2, 11'd120, 1'b0, 2, 1'b0);

    // Ties and negatives: first -7 at class 4 wins over class 8
    v = '{-1024, -1024, -1024, -1024, -7, -1024, -1024, -1024, -7, -1024};
    run_inf(pack(v), 30, 4'd4, 11'h7F9, 1'b0, 2, 1'b0);

    // Arbitration: host request blocks the inference request
    host_mem_req = 1'b1;
    req_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("arb_gnt_idle", 32'(host_mem_gnt), 32'd1);
      chk("arb_addr_idle", 32'(mem_addr), 32'hAAAA);
      chk("arb_req_ready", 32'(req_ready), 32'd0);
      chk("arb_busy", 32'(busy), 32'd0);
      tick();
    end
    host_mem_req = 1'b0;
    req_valid    = 1'b0;
    v = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    run_inf(pack(v), 10, 4'd0, 11'd5, 1'b0, 2, 1'b1);

    // Watchdog abort, with a late done ignored in HOLD
    v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    run_inf(pack(v), 0, 4'd0, 11'd0, 1'b1, 3, 1'b0);

    // Done outside RUN is ignored
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    #1;
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_start", 32'(eng_start), 32'd0);

    // Done on the last watchdog cycle wins; also 20 cycles of backpressure
    v = '{1, -2, 3, -4, 5, -6, 7, -8, 9, 1023};
    run_inf(pack(v), TO, 4'd9, 11'd1023, 1'b0, 20, 1'b0);

    // Reset in the middle of RUN discards the inference
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_eng_start", 32'(eng_start), 32'd0);
    chk("midrst_eng_reset", 32'(eng_reset), 32'd0);
    tick();
    #1;
    chk("midrst_idle_start", 32'(eng_start), 32'd0);
    v = '{-3, 7, 120, -1024, 5, 0, 119, 2, 3, 4};
    run_inf(pack(v), 50, 4'd2, 11'd120, 1'b0, 1, 1'b0);

    repeat (2) tick();
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
